// File: rtl/train_ctrl_pkg.sv
// Shared types and constants for the train station-stop controller.
// State codes, timer width, default phase durations, output decode.
package train_ctrl_pkg;

  localparam int TIMER_W = 13;

  typedef logic [TIMER_W-1:0] tmr_t;

  localparam tmr_t TMR_ZERO = '0;
  localparam tmr_t TMR_ONE  = tmr_t'(1);

  localparam tmr_t BRAKE_T_DEF  = 13'd4000;
  localparam tmr_t DWELL_T_DEF  = 13'd5000;
  localparam tmr_t WARN_T_DEF   = 13'd1000;
  localparam tmr_t DEPART_T_DEF = 13'd2000;

  typedef enum logic [2:0] {
    ST_PARK   = 3'd0,
    ST_RUN    = 3'd1,
    ST_BRAKE  = 3'd2,
    ST_DWELL  = 3'd3,
    ST_WARN   = 3'd4,
    ST_DEPART = 3'd5,
    ST_ESTOP  = 3'd6,
    ST_FAULT  = 3'd7
  } st_t;

  typedef struct packed {
    logic motor_en;
    logic brake;
    logic door_open;
    logic warn;
    logic fault;
  } drv_t;

  function automatic drv_t drv_of(input st_t s);
    drv_t d;
    d = '0;
    unique case (s)
      ST_RUN,
      ST_DEPART: d.motor_en = 1'b1;
      ST_PARK,
      ST_BRAKE,
      ST_ESTOP: d.brake = 1'b1;
      ST_DWELL: begin
        d.brake     = 1'b1;
        d.door_open = 1'b1;
      end
      ST_WARN: begin
        d.brake = 1'b1;
        d.warn  = 1'b1;
      end
      ST_FAULT: begin
        d.brake = 1'b1;
        d.fault = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/stop_timer.sv
// Saturating countdown shared by every timed phase of the stop cycle.
// A load of N makes done rise after exactly max(N,1) cycles in the phase.
module stop_timer
  import train_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               done
);

  tmr_t cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= TMR_ZERO;
    end else if (load) begin
      cnt <= (load_val == TMR_ZERO) ? TMR_ZERO
                                    : load_val - TMR_ONE;
    end else if (cnt != TMR_ZERO) begin
      cnt <= cnt - TMR_ONE;
    end
  end

  assign done = (cnt == TMR_ZERO);

endmodule

// File: rtl/train_stop_sequencer.sv
// Moore FSM for one train's station-stop cycle.
// One countdown timer is reloaded on every state entry.
module train_stop_sequencer
  import train_ctrl_pkg::*;
#(
  parameter tmr_t BRAKE_T  = BRAKE_T_DEF,
  parameter tmr_t DWELL_T  = DWELL_T_DEF,
  parameter tmr_t WARN_T   = WARN_T_DEF,
  parameter tmr_t DEPART_T = DEPART_T_DEF
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       station_req,
  input  logic       speed_zero,
  input  logic       door_closed,
  input  logic       emergency,
  output logic       motor_en,
  output logic       brake,
  output logic       door_open,
  output logic       warn,
  output logic       fault,
  output logic [2:0] state
);

  st_t  st_q;
  st_t  st_d;
  drv_t drv_q;
  logic ld;
  tmr_t ld_val;
  logic done;

  stop_timer u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .load_val (ld_val),
    .done     (done)
  );

  always_comb begin
    st_d = st_q;
    if (emergency && st_q != ST_FAULT) begin
      st_d = ST_ESTOP;
    end else begin
      unique case (st_q)
        ST_PARK:
          if (start) st_d = ST_DEPART;
        ST_RUN:
          if (station_req) st_d = ST_BRAKE;
        ST_BRAKE:
          if (speed_zero) st_d = ST_DWELL;
          else if (done)  st_d = ST_FAULT;
        ST_DWELL:
          if (done) st_d = ST_WARN;
        ST_WARN:
          if (done && door_closed) st_d = ST_DEPART;
        ST_DEPART:
          if (done) st_d = ST_RUN;
        ST_ESTOP:
          if (!emergency) st_d = ST_PARK;
        ST_FAULT:
          st_d = ST_FAULT;
        default:
          st_d = ST_PARK;
      endcase
    end
  end

  // Untimed states load zero, so ESTOP discards any pending count.
  always_comb begin
    ld     = (st_d != st_q);
    ld_val = TMR_ZERO;
    unique case (st_d)
      ST_BRAKE:  ld_val = BRAKE_T;
      ST_DWELL:  ld_val = DWELL_T;
      ST_WARN:   ld_val = WARN_T;
      ST_DEPART: ld_val = DEPART_T;
      default:   ld_val = TMR_ZERO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= ST_PARK;
      drv_q <= drv_of(ST_PARK);
    end else begin
      st_q  <= st_d;
      drv_q <= drv_of(st_d);
    end
  end

  assign motor_en  = drv_q.motor_en;
  assign brake     = drv_q.brake;
  assign door_open = drv_q.door_open;
  assign warn      = drv_q.warn;
  assign fault     = drv_q.fault;
  assign state     = st_q;

endmodule
